// File: rtl/npc_bpred.sv
// Next-PC unit: owns the fetch PC and predicts the next fetch address using a
// direct-mapped BTB with 2-bit saturating direction counters.
module npc_bpred #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_addr,
    input  logic             upd_valid,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [WIDTH-1:0] upd_target,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] NPC,
    output logic             pred_taken,
    output logic             pred_hit
);

    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned TAGW = WIDTH - IDXW - 2;

    logic [WIDTH-1:0] r_pc;
    logic             r_valid  [DEPTH];
    logic [1:0]       r_ctr    [DEPTH];
    logic [TAGW-1:0]  r_tag    [DEPTH];
    logic [WIDTH-1:0] r_target [DEPTH];

    // Word addresses: the byte offset bits take no part in lookup.
    logic [WIDTH-3:0] w_pc_word;
    logic [WIDTH-3:0] w_upd_word;
    logic [IDXW-1:0]  w_idx;
    logic [TAGW-1:0]  w_tag;
    logic [IDXW-1:0]  w_upd_idx;
    logic [TAGW-1:0]  w_upd_tag;
    logic             w_hit;
    logic             w_taken;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_npc;
    logic             w_upd_hit;
    logic [1:0]       w_ctr_cur;
    logic [1:0]       w_ctr_inc;
    logic [1:0]       w_ctr_dec;

    assign w_pc_word  = (WIDTH-2)'(r_pc >> 2);
    assign w_upd_word = (WIDTH-2)'(upd_pc >> 2);
    assign w_idx      = w_pc_word[IDXW-1:0];
    assign w_tag      = w_pc_word[WIDTH-3:IDXW];
    assign w_upd_idx  = w_upd_word[IDXW-1:0];
    assign w_upd_tag  = w_upd_word[WIDTH-3:IDXW];

    always_comb begin
        w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
        w_taken  = w_hit && r_ctr[w_idx][1];
        w_pc_inc = r_pc + WIDTH'(4);
        w_npc    = w_taken ? r_target[w_idx] : w_pc_inc;
    end

    always_comb begin
        w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
        w_ctr_cur = r_ctr[w_upd_idx];
        w_ctr_inc = (w_ctr_cur == 2'b11) ? w_ctr_cur : w_ctr_cur + 2'd1;
        w_ctr_dec = (w_ctr_cur == 2'b00) ? w_ctr_cur : w_ctr_cur - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_addr;
        end else if (!stall) begin
            r_pc <= w_npc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else if (upd_valid) begin
            if (w_upd_hit) begin
                r_ctr[w_upd_idx] <= upd_taken ? w_ctr_inc : w_ctr_dec;
            end else if (upd_taken) begin
                r_valid[w_upd_idx] <= 1'b1;
                r_ctr[w_upd_idx]   <= 2'b10;
            end
        end
    end

    // Tag/target carry no reset; a write landing during reset stays invisible
    // because the valid bit for that entry is held clear.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= upd_target;
        end
    end

    assign PC         = r_pc;
    assign NPC        = w_npc;
    assign pred_taken = w_taken;
    assign pred_hit   = w_hit;

endmodule

// File: tb/tb_npc_bpred.sv
// Self-checking bench for npc_bpred: an address-arithmetic BTB model checked
// every cycle, plus hand-computed expectations along a directed scenario.
module tb_npc_bpred;

    localparam int W = 32;
    localparam int D = 16;
    localparam logic [W-1:0] RST_PC = 32'h0000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         stall = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [W-1:0] redirect_addr = '0;
    logic         upd_valid = 1'b0;
    logic [W-1:0] upd_pc = '0;
    logic         upd_taken = 1'b0;
    logic [W-1:0] upd_target = '0;
    logic [W-1:0] PC;
    logic [W-1:0] NPC;
    logic         pred_taken;
    logic         pred_hit;

    int checks = 0;
    int failures = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;

    npc_bpred #(.WIDTH(W), .DEPTH(D), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target),
        .PC(PC), .NPC(NPC), .pred_taken(pred_taken), .pred_hit(pred_hit)
    );

    // Model: entries addressed by word number modulo D, tag is the quotient.
    logic [W-1:0] m_pc;
    bit           m_valid [D];
    logic [W-1:0] m_tagv  [D];
    logic [W-1:0] m_tgt   [D];
    int           m_ctr   [D];

    function automatic int idx_of(input logic [W-1:0] a);
        return int'((a / 4) % D);
    endfunction

    function automatic logic [W-1:0] tag_of(input logic [W-1:0] a);
        return a / (4 * D);
    endfunction

    function automatic bit m_hit(input logic [W-1:0] a);
        return m_valid[idx_of(a)] && (m_tagv[idx_of(a)] == tag_of(a));
    endfunction

    function automatic bit m_taken(input logic [W-1:0] a);
        return m_hit(a) && (m_ctr[idx_of(a)] >= 2);
    endfunction

    function automatic logic [W-1:0] m_npc(input logic [W-1:0] a);
        return m_taken(a) ? m_tgt[idx_of(a)] : a + 4;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [W-1:0] nxt;
        int           i;
        if (rst) begin
            m_pc = RST_PC;
            for (int k = 0; k < D; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
            end
        end else begin
            nxt = m_npc(m_pc);
            if (redirect_valid) m_pc = redirect_addr;
            else if (!stall)    m_pc = nxt;
            if (upd_valid) begin
                i = idx_of(upd_pc);
                if (m_hit(upd_pc)) begin
                    if (upd_taken) begin
                        if (m_ctr[i] < 3) m_ctr[i] = m_ctr[i] + 1;
                        m_tgt[i] = upd_target;
                    end else if (m_ctr[i] > 0) begin
                        m_ctr[i] = m_ctr[i] - 1;
                    end
                end else if (upd_taken) begin
                    m_valid[i] = 1'b1;
                    m_tagv[i]  = tag_of(upd_pc);
                    m_tgt[i]   = upd_target;
                    m_ctr[i]   = 2;
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run && !rst) begin
            cmp("model_pc",    PC,                 m_pc);
            cmp("model_npc",   NPC,                m_npc(m_pc));
            cmp("model_hit",   {31'b0, pred_hit},  {31'b0, m_hit(m_pc)});
            cmp("model_taken", {31'b0, pred_taken}, {31'b0, m_taken(m_pc)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic [W-1:0] pc, input logic tk, input logic [W-1:0] tgt);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    endtask

    task automatic clr();
        upd_valid = 1'b0; redirect_valid = 1'b0;
    endtask

    task automatic redir(input logic [W-1:0] a);
        redirect_valid = 1'b1; redirect_addr = a;
        step();
        clr();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run = 1'b1;
        cmp("rst_pc", PC, 32'h0);
        cmp("rst_npc", NPC, 32'h4);
        cmp("rst_hit", {31'b0, pred_hit}, 32'h0);
        cmp("rst_taken", {31'b0, pred_taken}, 32'h0);
        step(); cmp("seq_pc4", PC, 32'h4);
        step(); cmp("seq_pc8", PC, 32'h8);
        cmp("seq_hit", {31'b0, pred_hit}, 32'h0);

        set_upd(32'h10, 1'b1, 32'h40); step(); clr();
        cmp("alloc_pc_c", PC, 32'hC);
        step();
        cmp("alloc_pc", PC, 32'h10);
        cmp("alloc_hit", {31'b0, pred_hit}, 32'h1);
        cmp("alloc_taken", {31'b0, pred_taken}, 32'h1);
        cmp("alloc_npc", NPC, 32'h40);
        step(); cmp("jump_pc", PC, 32'h40);

        stall = 1'b1;
        redir(32'h10);
        repeat (4) begin set_upd(32'h10, 1'b0, 32'h0); step(); end
        clr();
        cmp("dec_pc", PC, 32'h10);
        cmp("dec_hit", {31'b0, pred_hit}, 32'h1);
        cmp("dec_taken", {31'b0, pred_taken}, 32'h0);
        cmp("dec_npc", NPC, 32'h14);
        set_upd(32'h10, 1'b1, 32'h44); step();
        cmp("sat_lo_taken", {31'b0, pred_taken}, 32'h0);
        cmp("sat_lo_npc", NPC, 32'h14);
        step(); clr();
        cmp("retrain_taken", {31'b0, pred_taken}, 32'h1);
        cmp("retrain_npc", NPC, 32'h44);

        redir(32'h100);
        cmp("flush_over_stall", PC, 32'h100);
        repeat (2) step();
        cmp("stall_hold", PC, 32'h100);

        set_upd(32'h50, 1'b1, 32'h80);
        redirect_valid = 1'b1; redirect_addr = 32'h10;
        step(); clr();
        cmp("alias_pc", PC, 32'h10);
        cmp("alias_hit", {31'b0, pred_hit}, 32'h0);
        cmp("alias_npc", NPC, 32'h14);
        redir(32'h50);
        cmp("alias_new_hit", {31'b0, pred_hit}, 32'h1);
        cmp("alias_new_npc", NPC, 32'h80);

        redir(32'h10);
        set_upd(32'h10, 1'b1, 32'h60);
        #2;
        cmp("nobypass_hit", {31'b0, pred_hit}, 32'h0);
        cmp("nobypass_npc", NPC, 32'h14);
        step(); clr();
        cmp("after_wr_hit", {31'b0, pred_hit}, 32'h1);
        cmp("after_wr_npc", NPC, 32'h60);

        set_upd(32'h20, 1'b0, 32'h99); step(); clr();
        redir(32'h20);
        cmp("miss_nt_hit", {31'b0, pred_hit}, 32'h0);
        cmp("miss_nt_npc", NPC, 32'h24);

        stall = 1'b0;
        redir(32'hFFFF_FFFC);
        cmp("wrap_npc", NPC, 32'h0);
        step(); cmp("wrap_pc", PC, 32'h0);

        stall = 1'b1;
        redir(32'h10);
        cmp("pre_rst_hit", {31'b0, pred_hit}, 32'h1);
        #2 rst = 1'b1;
        #1;
        cmp("async_pc", PC, RST_PC);
        cmp("async_hit", {31'b0, pred_hit}, 32'h0);
        cmp("async_npc", NPC, 32'h4);
        set_upd(32'h30, 1'b1, 32'h90);
        redirect_valid = 1'b1; redirect_addr = 32'h200;
        step(); clr();
        #2 rst = 1'b0;
        cmp("rst_drop_redir", PC, RST_PC);
        redir(32'h10);
        cmp("rst_clr_valid", {31'b0, pred_hit}, 32'h0);
        redir(32'h30);
        cmp("rst_drop_upd", {31'b0, pred_hit}, 32'h0);
        cmp("rst_drop_npc", NPC, 32'h34);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npc_bpred.md
Name: npc_bpred

Overview:
- Next-generation next-PC unit: owns the fetch PC register and predicts the next fetch address.
- Prediction uses a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- EX stage supplies a redirect (mispredict or unpredicted jump) and a resolved-branch update.
- Sits at the front of the IF stage and feeds the instruction-memory address and the IF/ID PC.

Parameters:
WIDTH, 32, address/PC width in bits
DEPTH, 16, BTB entries; power of two, minimum 2; IDXW = log2(DEPTH)
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
stall  input  1  hold PC (load-use / structural stall)
redirect_valid  input  1  EX-stage redirect request
redirect_addr  input  WIDTH  correct next PC from EX
upd_valid  input  1  resolved control-flow instruction update
upd_pc  input  WIDTH  PC of the resolved instruction
upd_taken  input  1  resolved direction
upd_target  input  WIDTH  resolved target address
PC  output  WIDTH  current fetch PC (registered)
NPC  output  WIDTH  predicted next PC (combinational from PC and BTB)
pred_taken  output  1  prediction for the instruction at PC; pipelined to EX by the caller
pred_hit  output  1  BTB tag hit for PC

Behaviour:
- Addressing:
  - index = addr[IDXW+1:2]
  - tag = addr[WIDTH-1:IDXW+2]
  - addr[1:0] are ignored for lookup.
- Entry contents: valid bit, tag, target[WIDTH-1:0], ctr[1:0].
  - ctr encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Lookup (combinational on PC):
  - pred_hit = valid[index] && tag match.
  - pred_taken = pred_hit && ctr[1].
  - NPC = pred_taken ? target : PC+4.
  - PC+4 wraps modulo 2^WIDTH.
- PC register update, on rising clk, in priority order:
  - rst: PC = RESET_PC.
  - redirect_valid: PC = redirect_addr, even when stall=1, since a flush overrides a stall. All WIDTH bits load unmodified.
  - !stall: PC = NPC.
  - otherwise: PC holds.
- BTB update, on rising clk when upd_valid=1, at index/tag of upd_pc:
  - Hit and upd_taken: ctr saturating increment (11 stays 11); target = upd_target.
  - Hit and !upd_taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss and upd_taken: allocate the entry: valid=1, new tag, target = upd_target, ctr=10. Any existing entry at that index is replaced.
  - Miss and !upd_taken: no change.
- Stall has no effect on BTB updates.
- Read/write ordering:
  - A lookup in the same cycle as an update to the same index sees the pre-update contents.
  - The new contents are visible the cycle after the clock edge.
  - There is no bypass.
- Redirect and update in the same cycle are independent: both take effect at the same edge.
- Reset, asynchronous and immediate:
  - PC = RESET_PC.
  - All valid = 0.
  - All ctr = 01.
  - Targets and tags are don't-care.
  - After reset: pred_hit=0, pred_taken=0, NPC=RESET_PC+4.
- Reset asserted mid-operation discards any pending update or redirect at that edge. The first edge after deassertion behaves normally.
- No X on outputs after reset regardless of target/tag storage contents, because valid gates the hit.

Test Plan:
- Reset then release with stall=0, no updates: PC = 0x0, 0x4, 0x8 on successive edges; pred_hit=0 throughout.
- Update upd_pc=0x10, taken, target=0x40; later PC reaches 0x10: pred_hit=1, pred_taken=1 (ctr=10), NPC=0x40, next PC=0x40.
- Four not-taken updates on the 0x10 entry: ctr steps 10, 01, 00, 00 (saturates); at PC=0x10, pred_taken=0, NPC=0x14.
- stall=1 and redirect_valid=1 with redirect_addr=0x100 in the same cycle: next PC=0x100. Then stall=1 alone: PC holds at 0x100.
- DEPTH=16 aliasing: taken update at 0x10, then taken update at 0x50 (same index, different tag) -> 0x50 replaces the entry. PC=0x10 then gives pred_hit=0 and NPC=0x14.
- WIDTH=32 wrap, plus async reset: at PC=0xFFFF_FFFC with a BTB miss, next PC=0x0000_0000. Asserting rst between edges forces PC=RESET_PC immediately and clears all valid bits.
